// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, func codes, FSM state encoding and status-bit indices
// for the ALU sequencer, plus the add/sub flag helper.
package alu_pkg;

  localparam logic [3:0] OP_ADDSUB = 4'b0000;
  localparam logic [3:0] OP_AND    = 4'b0001;
  localparam logic [3:0] OP_OR     = 4'b0010;
  localparam logic [3:0] OP_XOR    = 4'b0011;
  localparam logic [3:0] OP_SHIFT  = 4'b0100;
  localparam logic [3:0] OP_SUB    = 4'b0101;
  localparam logic [3:0] OP_NOT    = 4'b0110;
  localparam logic [3:0] OP_MOV    = 4'b0111;
  localparam logic [3:0] OP_STORE  = 4'b1000;
  localparam logic [3:0] OP_LOAD   = 4'b1001;
  localparam logic [3:0] OP_MUL    = 4'b1010;
  localparam logic [3:0] OP_ADDI   = 4'b1011;
  localparam logic [3:0] OP_LUI    = 4'b1100;
  localparam logic [3:0] OP_CMOV   = 4'b1101;
  localparam logic [3:0] OP_BRANCH = 4'b1110;
  localparam logic [3:0] OP_UNDEF  = 4'b1111;

  localparam logic [2:0] FN_ADD = 3'b000;
  localparam logic [2:0] FN_SUB = 3'b001;

  localparam int ST_OF = 0;
  localparam int ST_C  = 1;
  localparam int ST_N  = 2;
  localparam int ST_Z  = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_STALL  = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  // C is carry-out for add and borrow for sub; both fall out of bit 16 of the 17-bit result.
  function automatic logic [3:0] calc_flags(input logic [15:0] a, input logic [15:0] b,
                                            input logic sub);
    logic [16:0] w_res;
    logic [3:0]  w_f;
    w_res = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    w_f        = 4'b0000;
    w_f[ST_Z]  = (w_res[15:0] == 16'h0000);
    w_f[ST_N]  = w_res[15];
    w_f[ST_C]  = w_res[16];
    w_f[ST_OF] = sub ? ((a[15] != b[15]) && (w_res[15] != a[15]))
                     : ((a[15] == b[15]) && (w_res[15] != a[15]));
    return w_f;
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: NREGS x W register file, two combinational read ports,
// one synchronous write port, cleared by synchronous reset.
module alu_seq_regfile
  import alu_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int W     = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] i_raddr_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [W-1:0]  o_rdata_a,
  output logic [W-1:0]  o_rdata_b,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata
);

  logic [W-1:0] r_mem [NREGS];

  // Register storage: reset clear, otherwise single-port write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= {W{1'b0}};
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: fetch/decode/execute/writeback sequencer for the 16-bit ALU datapath.
// Defining ALU_SEQ_CTRL_STEP_EN adds a step input; each WB then waits in STALL for step.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int              NREGS    = 8,
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
`ifdef ALU_SEQ_CTRL_STEP_EN
  input  logic            step,
`endif
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [3:0]      alu_opcode,
  output logic [2:0]      alu_func,
  output logic [15:0]     alu_op_a,
  output logic [15:0]     alu_op_b,
  output logic [8:0]      alu_jaddr,
  output logic            alu_we,
  output logic [15:0]     status,
  input  logic [15:0]     alu_result,
  output logic            busy,
  output logic            halted
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic [3:0]      r_status;
  logic            r_req, r_busy, r_halted;
  logic [3:0]      r_opcode;
  logic [2:0]      r_func;
  logic [15:0]     r_op_a, r_op_b;
  logic [8:0]      r_jaddr;

  logic [15:0]     w_rdata_a, w_rdata_b;
  logic            w_flag_op, w_sub, w_wr_op, w_halt, w_rf_we;
  logic [3:0]      w_flags;
  logic [PC_W-1:0] w_pc_nxt;

  alu_seq_regfile #(.NREGS(NREGS), .W(16)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_raddr_a (r_ir[8:6]),
    .i_raddr_b (r_ir[5:3]),
    .o_rdata_a (w_rdata_a),
    .o_rdata_b (w_rdata_b),
    .i_we      (w_rf_we),
    .i_waddr   (r_ir[11:9]),
    .i_wdata   (alu_result)
  );

  assign w_flag_op = ((r_opcode == OP_ADDSUB) && ((r_func == FN_ADD) || (r_func == FN_SUB)))
                   || (r_opcode == OP_SUB);
  assign w_sub     = (r_opcode == OP_SUB) || (r_func == FN_SUB);
  assign w_flags   = calc_flags(r_op_a, r_op_b, w_sub);
  assign w_rf_we   = (r_state == S_WB) && w_wr_op;

  // Writeback decision: register write, next PC, or halt, from the latched opcode and flags.
  always_comb begin
    w_wr_op  = 1'b0;
    w_halt   = 1'b0;
    w_pc_nxt = r_pc + PC_ONE;
    case (r_opcode)
      OP_STORE, OP_MUL: w_wr_op = 1'b0;
      OP_CMOV: begin
        if (r_status[ST_N] || r_status[ST_Z]) w_wr_op = 1'b1;
        else                                  w_halt  = 1'b1;
      end
      OP_BRANCH: begin
        if (|r_status) w_pc_nxt = r_pc + r_jaddr[PC_W-1:0];
        else           w_halt   = 1'b1;
      end
      OP_UNDEF: w_halt  = 1'b1;
      default:  w_wr_op = 1'b1;
    endcase
  end

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_ir     <= 16'h0000;
      r_status <= 4'b0000;
      r_req    <= 1'b0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
      r_opcode <= 4'b0000;
      r_func   <= 3'b000;
      r_op_a   <= 16'h0000;
      r_op_b   <= 16'h0000;
      r_jaddr  <= 9'h000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_ir    <= imem_data;
            r_req   <= 1'b0;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_opcode <= r_ir[15:12];
          r_func   <= r_ir[2:0];
          r_op_a   <= w_rdata_a;
          r_op_b   <= w_rdata_b;
          r_jaddr  <= r_ir[8:0];
          r_state  <= S_EXEC;
        end
        S_EXEC: begin
          if (w_flag_op) r_status <= w_flags;
          r_state <= S_WB;
        end
        S_WB: begin
          if (w_halt) begin
            r_state  <= S_HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else begin
            r_pc <= w_pc_nxt;
`ifdef ALU_SEQ_CTRL_STEP_EN
            r_state <= S_STALL;
`else
            r_state <= S_FETCH;
            r_req   <= 1'b1;
`endif
          end
        end
`ifdef ALU_SEQ_CTRL_STEP_EN
        S_STALL: begin
          if (step) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end
        end
`endif
        S_HALT: r_state <= S_HALT;
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = r_req;
  assign imem_addr  = r_pc;
  assign alu_opcode = r_opcode;
  assign alu_func   = r_func;
  assign alu_op_a   = r_op_a;
  assign alu_op_b   = r_op_b;
  assign alu_jaddr  = r_jaddr;
  assign alu_we     = 1'b0;
  assign status     = {12'h000, r_status};
  assign busy       = r_busy;
  assign halted     = r_halted;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed program run against an instruction-level model of the
// sequencer; outputs compared every cycle at negedge, plus literal spot checks.
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, imem_ack;
  logic [15:0] imem_data, alu_result;
  logic        imem_req, alu_we, busy, halted;
  logic [7:0]  imem_addr;
  logic [3:0]  alu_opcode;
  logic [2:0]  alu_func;
  logic [15:0] alu_op_a, alu_op_b, status;
  logic [8:0]  alu_jaddr;
`ifdef ALU_SEQ_CTRL_STEP_EN
  logic        step;
`endif

  alu_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef ALU_SEQ_CTRL_STEP_EN
    .step(step),
`endif
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .alu_opcode(alu_opcode), .alu_func(alu_func), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
    .alu_jaddr(alu_jaddr), .alu_we(alu_we), .status(status), .alu_result(alu_result),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_reg [8];
  logic [7:0]  m_pc;
  logic [3:0]  m_st;
  logic        e_req, e_busy, e_halted;
  logic [3:0]  e_opcode;
  logic [2:0]  e_func;
  logic [15:0] e_a, e_b;
  logic [8:0]  e_jaddr;
  bit          chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req", imem_req, e_req);
      chk("imem_addr", imem_addr, m_pc);
      chk("busy", busy, e_busy);
      chk("halted", halted, e_halted);
      chk("status", status, {12'h000, m_st});
      chk("alu_opcode", alu_opcode, e_opcode);
      chk("alu_func", alu_func, e_func);
      chk("alu_op_a", alu_op_a, e_a);
      chk("alu_op_b", alu_op_b, e_b);
      chk("alu_jaddr", alu_jaddr, e_jaddr);
      chk("alu_we", alu_we, 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
    m_pc = 8'h00; m_st = 4'h0;
    e_req = 1'b0; e_busy = 1'b0; e_halted = 1'b0;
    e_opcode = 4'h0; e_func = 3'h0; e_a = 16'h0000; e_b = 16'h0000; e_jaddr = 9'h000;
  endtask

  // Flags from integer arithmetic: {Z, N, C, OF}.
  function automatic logic [3:0] model_flags(input logic [15:0] a, input logic [15:0] b,
                                             input bit sub);
    int ua, ub, sa, sb, ur, sr;
    logic [15:0] r;
    logic [3:0]  f;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    ur = sub ? ua - ub : ua + ub;
    sr = sub ? sa - sb : sa + sb;
    r  = ur[15:0];
    f[3] = (r == 16'h0000);
    f[2] = r[15];
    f[1] = sub ? (ua < ub) : (ur > 65535);
    f[0] = (sr > 32767) || (sr < -32768);
    return f;
  endfunction

  // Entered with the DUT freshly in FETCH; returns with it in the next FETCH or HALT.
  task automatic run_instr(input logic [15:0] ins, input logic [15:0] res, input int dly);
    logic [3:0] op;
    logic [2:0] rd, rs, rt, fn;
    bit halt_now, wr;
    op = ins[15:12]; rd = ins[11:9]; rs = ins[8:6]; rt = ins[5:3]; fn = ins[2:0];
    for (int i = 0; i < dly; i++) tick();
    imem_data = ins; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0; imem_data = 16'hFFFF; alu_result = res; e_req = 1'b0;
    tick();
    e_opcode = op; e_func = fn; e_a = m_reg[rs]; e_b = m_reg[rt]; e_jaddr = ins[8:0];
    tick();
    if ((op == 4'b0000 && fn <= 3'b001) || op == 4'b0101)
      m_st = model_flags(e_a, e_b, (op == 4'b0101) || (fn == 3'b001));
    tick();
    halt_now = 1'b0; wr = 1'b1;
    case (op)
      4'b1000, 4'b1010: wr = 1'b0;
      4'b1101: if (!(m_st[2] || m_st[3])) begin halt_now = 1'b1; wr = 1'b0; end
      4'b1110: begin wr = 1'b0; if (m_st == 4'h0) halt_now = 1'b1; end
      4'b1111: begin wr = 1'b0; halt_now = 1'b1; end
      default: wr = 1'b1;
    endcase
    if (wr) m_reg[rd] = res;
    if (halt_now) begin
      e_busy = 1'b0; e_halted = 1'b1; e_req = 1'b0;
    end else begin
      m_pc = (op == 4'b1110) ? m_pc + ins[7:0] : m_pc + 8'h01;
`ifdef ALU_SEQ_CTRL_STEP_EN
      e_req = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      step = 1'b1;
      tick();
      step = 1'b0;
`endif
      e_req = 1'b1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0; e_req = 1'b1; e_busy = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_data = 16'h0000; alu_result = 16'h0000;
`ifdef ALU_SEQ_CTRL_STEP_EN
    step = 1'b0;
`endif
    model_reset();
    tick(); tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    imem_ack = 1'b1; imem_data = 16'hF000;
    tick();
    imem_ack = 1'b0;
    tick();
    do_start();

    run_instr(16'h0008, 16'h0000, 1);
    chk("t1_status", status, 16'h0008);
    chk("t1_addr", imem_addr, 8'h01);
    chk("t1_req", imem_req, 1'b1);

    run_instr(16'h7200, 16'h7FFF, 0);
    run_instr(16'h7400, 16'h0001, 0);
    run_instr(16'h0650, 16'h8000, 0);
    chk("ovf_status", status, 16'h0005);
    run_instr(16'h5800, 16'h0000, 0);
    chk("pc5", imem_addr, 8'h05);
    run_instr(16'hE010, 16'hDEAD, 0);
    chk("br_taken", imem_addr, 8'h15);
    run_instr(16'h8000, 16'hBEEF, 2);
    run_instr(16'hDA00, 16'h1234, 0);
    run_instr(16'h7C28, 16'hAAAA, 0);
    run_instr(16'hE0E7, 16'h0000, 0);
    chk("pc_ff", imem_addr, 8'hFF);
    run_instr(16'h7000, 16'h0005, 0);
    chk("pc_wrap", imem_addr, 8'h00);
    run_instr(16'h5E88, 16'h8002, 0);
    chk("borrow_status", status, 16'h0006);
    run_instr(16'h0ED8, 16'h0000, 0);
    chk("carry_status", status, 16'h000B);
    run_instr(16'hAE00, 16'h5555, 0);
    run_instr(16'h71F8, 16'h0000, 0);
    run_instr(16'h0082, 16'h7777, 0);
    run_instr(16'h0080, 16'h7778, 0);
    chk("clear_status", status, 16'h0000);
    run_instr(16'hE010, 16'h0000, 0);
    chk("halt_flag", halted, 1'b1);
    start = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    start = 1'b0;
    tick();
    chk("halt_sticky_req", imem_req, 1'b0);

    rst = 1'b1;
    tick();
    rst = 1'b0; model_reset();
    tick();
    do_start();
    imem_data = 16'h7200; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0; e_req = 1'b0; alu_result = 16'h4321;
    tick();
    e_opcode = 4'h7; e_func = 3'h0; e_a = m_reg[0]; e_b = m_reg[0]; e_jaddr = 9'h000;
    rst = 1'b1;
    tick();
    rst = 1'b0; model_reset();
    chk("rst_busy", busy, 1'b0);
    chk("rst_opcode", alu_opcode, 4'h0);
    tick();
    do_start();
    run_instr(16'h0050, 16'h0000, 0);
    run_instr(16'hF000, 16'h0000, 0);
    chk("undef_halt", halted, 1'b1);
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
